// File: rtl/threshold_loader_pkg.sv
// Shared definitions for the comparator threshold-table loader: FSM encoding and
// width helpers used by the loader, the comparator and the wrapper.
package threshold_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

  // Accumulator holds cnt * K exactly, so it needs cnt bits plus every bit of K.
  function automatic int acc_width(input int cnt_w, input int int_w, input int frac_w);
    return cnt_w + int_w + frac_w;
  endfunction

  // Threshold entries are one bit wider than a count: they compare against CntA+CntB.
  function automatic int entry_width(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/threshold_loader.sv
// Streams the Tanimoto threshold table Result[c] = sat(ceil(c*K)), c = 0..VECTOR_WIDTH,
// into the comparator result RAM, one entry per cycle, using a running sum instead of a multiplier.
module threshold_loader
  import threshold_loader_pkg::*;
#(
  parameter int VECTOR_WIDTH = 920,
  parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
  parameter int INT_WIDTH    = 4,
  parameter int FRAC_WIDTH   = 16,
  parameter int ACC_WIDTH    = acc_width(CNT_WIDTH, INT_WIDTH, FRAC_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_Start,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] i_Mult,
  output logic [CNT_WIDTH-1:0]           o_Addr,
  output logic [CNT_WIDTH:0]             o_Din,
  output logic                           o_WrEn,
  output logic                           o_Busy,
  output logic                           o_Done,
  output logic                           o_Loaded
);

  localparam int ENTRY_W = entry_width(CNT_WIDTH);
  localparam int MULT_W  = INT_WIDTH + FRAC_WIDTH;

  load_state_t                state_q, state_d;
  logic [MULT_W-1:0]          mult_q, mult_d;
  logic [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]       addr_q, addr_d;
  logic [ENTRY_W-1:0]         din_q, din_d;
  logic                       wr_en_q, wr_en_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       loaded_q, loaded_d;

  // Round up to the next integer, then clamp; an all-ones entry can never be reached
  // by CntA+CntB, so it reads as "never under threshold".
  function automatic logic [ENTRY_W-1:0] ceil_sat(input logic [ACC_WIDTH-1:0] acc);
    logic [ACC_WIDTH:0] rnd;
    logic [ACC_WIDTH:0] q;
    rnd = {1'b0, acc} + {{(ACC_WIDTH+1-FRAC_WIDTH){1'b0}}, {FRAC_WIDTH{1'b1}}};
    q   = rnd >> FRAC_WIDTH;
    if (|q[ACC_WIDTH:ENTRY_W]) begin
      return '1;
    end
    return q[ENTRY_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_Start) state_d = ST_LOAD;
      ST_LOAD: if (cnt_q == CNT_WIDTH'(VECTOR_WIDTH)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mult_d   = mult_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wr_en_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    loaded_d = loaded_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          mult_d   = i_Mult;
          acc_d    = '0;
          cnt_d    = '0;
          loaded_d = 1'b0;
        end
      end
      ST_LOAD: begin
        wr_en_d = 1'b1;
        busy_d  = 1'b1;
        addr_d  = cnt_q;
        din_d   = ceil_sat(acc_q);
        acc_d   = acc_q + ACC_WIDTH'(mult_q);
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
      ST_DONE: begin
        done_d   = 1'b1;
        loaded_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath; address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      mult_q   <= mult_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wr_en_q  <= wr_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
    end
  end

  assign o_Addr   = addr_q;
  assign o_Din    = din_q;
  assign o_WrEn   = wr_en_q;
  assign o_Busy   = busy_q;
  assign o_Done   = done_q;
  assign o_Loaded = loaded_q;

endmodule
